// File: rtl/ecc_pkg.sv
// Shared ECC codeword geometry and the tagged byte format carried through the packer buffer.
package ecc_pkg;

    localparam int CW_LEN   = 256;
    localparam int DATA_LEN = 252;
    localparam int PAR_LEN  = 4;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } cw_byte_t;

endpackage

// File: rtl/ecc_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, 1-cycle read latency, no reset.
module ecc_sdp_ram #(
    parameter int DW = 9,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ecc_cw_packer.sv
// Buffers encoder bytes into whole codewords and streams them out over AXI-Stream with tlast on
// the final byte of each codeword; bytes arriving while the buffer is full are dropped.
module ecc_cw_packer
    import ecc_pkg::*;
#(
    parameter int CW_LEN   = ecc_pkg::CW_LEN,
    parameter int DEPTH_CW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_tdata,
    input  logic       in_tvalid,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       space_ok,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int DEPTH = CW_LEN * DEPTH_CW;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int WW    = $clog2(CW_LEN);

    logic [2:0]    rst_sync;
    logic          srst_n;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] ram_cnt;
    logic [PW-1:0] fill;
    logic [PW-1:0] fill_next;
    logic [WW-1:0] wcnt;

    logic          full;
    logic          ram_empty;
    logic          wr_en;
    logic          rd_issue;
    logic          rd_pend;
    logic          pop;
    logic          load_out;
    logic [1:0]    occ;

    logic          hold_vld;
    logic          out_vld;
    cw_byte_t      wr_word;
    cw_byte_t      ram_q;
    cw_byte_t      hold_q;
    cw_byte_t      out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[1:0], 1'b1};
        end
    end

    assign srst_n = rst_sync[2];

    // fill counts every accepted byte not yet handed off: RAM, read in flight, skid and output regs
    always_comb begin
        ram_cnt      = wptr - rptr;
        fill         = ram_cnt + PW'(rd_pend) + PW'(hold_vld) + PW'(out_vld);
        full         = (fill == PW'(DEPTH));
        wr_en        = in_tvalid && !full;
        pop          = out_vld && m_axis_tready;
        load_out     = !out_vld || pop;
        ram_empty    = (wptr == rptr);
        occ          = 2'(rd_pend) + 2'(hold_vld) + 2'(out_vld) - 2'(pop);
        rd_issue     = !ram_empty && (occ <= 2'd1);
        fill_next    = fill + PW'(wr_en) - PW'(pop);
        wr_word.last = (wcnt == WW'(CW_LEN - 1));
        wr_word.data = in_tdata;
    end

    ecc_sdp_ram #(
        .DW ($bits(cw_byte_t)),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr[AW-1:0]),
        .wdata (wr_word),
        .re    (rd_issue),
        .raddr (rptr[AW-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            wcnt     <= '0;
            rd_pend  <= 1'b0;
            overflow <= 1'b0;
            space_ok <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (in_tvalid) begin
                wcnt <= (wcnt == WW'(CW_LEN - 1)) ? '0 : wcnt + 1'b1;
            end
            if (rd_issue) begin
                rptr <= rptr + 1'b1;
            end
            rd_pend <= rd_issue;
            if (in_tvalid && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            space_ok <= (PW'(DEPTH) - fill_next) >= PW'(CW_LEN);
        end
    end

    // Skid register absorbs a read already in flight when the output register stalls,
    // which lets reads issue every cycle for back-to-back transfers.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            out_vld  <= 1'b0;
            out_q    <= '0;
            hold_vld <= 1'b0;
            hold_q   <= '0;
        end else begin
            if (load_out) begin
                if (hold_vld) begin
                    out_vld <= 1'b1;
                    out_q   <= hold_q;
                end else if (rd_pend) begin
                    out_vld <= 1'b1;
                    out_q   <= ram_q;
                end else begin
                    out_vld <= 1'b0;
                end
            end
            if (hold_vld) begin
                if (load_out) begin
                    hold_vld <= rd_pend;
                    hold_q   <= ram_q;
                end
            end else if (rd_pend && !load_out) begin
                hold_vld <= 1'b1;
                hold_q   <= ram_q;
            end
        end
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tlast  = out_q.last && out_vld;

endmodule

// File: tb/tb_ecc_cw_packer.sv
// Self-checking bench: random traffic against a queue-based codeword packer model.
module tb_ecc_cw_packer;

    localparam int CW    = 256;
    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_tdata;
    logic       in_tvalid;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       space_ok;
    logic       overflow;
    logic       ovf_clr;

    ecc_cw_packer #(
        .CW_LEN   (CW),
        .DEPTH_CW (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_tdata      (in_tdata),
        .in_tvalid     (in_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .space_ok      (space_ok),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] mq[$];
    int         m_wcnt;
    bit         m_ovf;
    int         rst_cnt;
    int         n_out;
    int         n_tlast;
    int         n_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model by the rules of the packer, compare outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        logic       tv;
        logic       tl;
        logic [7:0] td;
        logic [8:0] e;
        bit         full_pre;
        in_tvalid     = v;
        in_tdata      = d;
        m_axis_tready = rdy;
        ovf_clr       = clr;
        tv = m_axis_tvalid;
        td = m_axis_tdata;
        tl = m_axis_tlast;
        @(posedge clk);
        #1;
        if (rst_cnt < 3) begin
            rst_cnt++;
            check("rel_tvalid", m_axis_tvalid, 0);
            check("rel_space_ok", space_ok, 0);
        end else begin
            full_pre = (mq.size() == DEPTH);
            if (tv && rdy) begin
                if (mq.size() == 0) begin
                    check("spurious_valid", tv, 0);
                end else begin
                    e = mq.pop_front();
                    check("tdata", td, e[7:0]);
                    check("tlast", tl, e[8]);
                    n_out++;
                    if (tl) n_tlast++;
                end
            end
            if (v) begin
                if (full_pre) begin
                    m_ovf = 1'b1;
                    n_drop++;
                end else begin
                    mq.push_back({1'(m_wcnt == CW - 1), d});
                end
                m_wcnt = (m_wcnt + 1) % CW;
            end
            if (!(v && full_pre) && clr) m_ovf = 1'b0;
            check("overflow", overflow, m_ovf);
            check("space_ok", space_ok, 32'((DEPTH - mq.size()) >= CW));
            if (tv && !rdy) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", {m_axis_tlast, m_axis_tdata}, {tl, td});
            end
        end
    endtask

    task automatic apply_reset();
        in_tvalid     = 1'b0;
        in_tdata      = '0;
        ovf_clr       = 1'b0;
        m_axis_tready = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_overflow", overflow, 0);
        check("rst_space_ok", space_ok, 0);
        mq.delete();
        m_wcnt  = 0;
        m_ovf   = 1'b0;
        rst_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic settle();
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("settle_space_ok", space_ok, 1);
    endtask

    task automatic drain(input string tag, input bit rand_ready);
        for (int i = 0; i < 5000 && (mq.size() != 0 || m_axis_tvalid); i++)
            step(1'b0, 8'h00, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        check(tag, mq.size(), 0);
    endtask

    task automatic clear_counts();
        n_out   = 0;
        n_tlast = 0;
        n_drop  = 0;
    endtask

    initial begin
        int t_first;
        rst_n         = 1'b0;
        in_tvalid     = 1'b0;
        in_tdata      = '0;
        ovf_clr       = 1'b0;
        m_axis_tready = 1'b0;
        rst_cnt       = 0;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();
        settle();

        // Contiguous 0x00..0xFF with tready high: latency, order, single tlast, no gaps
        clear_counts();
        t_first = -1;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            if (t_first < 0 && m_axis_tvalid) t_first = i;
            if (t_first >= 0 && mq.size() != 0) check("t1_no_gap", m_axis_tvalid, 1);
        end
        check("t1_latency", t_first, 2);
        for (int i = 0; i < 300 && mq.size() != 0; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (mq.size() != 0) check("t1_no_gap", m_axis_tvalid, 1);
        end
        check("t1_drained", mq.size(), 0);
        check("t1_count", n_out, 256);
        check("t1_tlast_cnt", n_tlast, 1);

        // Stalled sink, two codewords: space_ok boundary, no drops, then full release
        clear_counts();
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            if (i == 255) check("t2_space_after_256", space_ok, 1);
            if (i == 256) check("t2_space_after_257", space_ok, 0);
        end
        check("t2_no_ovf", overflow, 0);
        drain("t2_drained", 1'b0);
        check("t2_count", n_out, 512);
        check("t2_tlast_cnt", n_tlast, 2);

        // Full buffer, then writes coinciding with reads: first byte dropped, alignment kept
        clear_counts();
        for (int i = 0; i < 512; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (i == 0) check("t3_drop_sets_ovf", overflow, 1);
        end
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b0, 1'b1);
        check("t3_set_beats_clr", overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_clr", overflow, 0);
        drain("t3_drained", 1'b0);
        check("t3_drops", n_drop, 2);
        check("t3_count", n_out, 768);
        check("t3_tlast_cnt", n_tlast, 3);

        apply_reset();
        settle();

        // Eight codewords paced by space_ok with a randomly stalling sink
        clear_counts();
        for (int cw = 0; cw < 8; cw++) begin
            for (int w = 0; w < 3000 && !space_ok; w++)
                step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            check("t4_space_ok", space_ok, 1);
            for (int i = 0; i < 256; i++)
                step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain("t4_drained", 1'b1);
        check("t4_count", n_out, 2048);
        check("t4_tlast_cnt", n_tlast, 8);
        check("t4_no_drop", n_drop, 0);
        check("t4_no_ovf", overflow, 0);

        // Reset in the middle of a codeword, then a fresh codeword emerges whole
        for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("t5_valid_before", m_axis_tvalid, 1);
        apply_reset();
        settle();
        clear_counts();
        for (int i = 0; i < 256; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        drain("t5_drained", 1'b0);
        check("t5_count", n_out, 256);
        check("t5_tlast_cnt", n_tlast, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
